// File: rtl/trap_csr.sv
// trap_csr: machine-mode CSR responder and trap sequencer for the rv32 core.
// Serves Zicsr accesses, arbitrates exceptions/interrupts/mret and requests
// fetch redirects through a two-state IDLE/REDIRECT handshake.
// Build option: define TRAP_CSR_COUNTERS_EN to implement 64-bit mcycle and
// minstret plus mcountinhibit; otherwise those addresses read 0, ignore
// writes and remain legal.
module trap_csr #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic        csr_wr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        csr_ready,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic [31:0] irq_pc,
  input  logic        meip,
  input  logic        msip,
  input  logic        mtip,
  input  logic        mret,
  input  logic        inst_retired,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        irq_pending
);

  typedef enum logic [11:0] {
    CSR_MSTATUS       = 12'h300,
    CSR_MISA          = 12'h301,
    CSR_MIE           = 12'h304,
    CSR_MTVEC         = 12'h305,
    CSR_MSTATUSH      = 12'h310,
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MSCRATCH      = 12'h340,
    CSR_MEPC          = 12'h341,
    CSR_MCAUSE        = 12'h342,
    CSR_MTVAL         = 12'h343,
    CSR_MIP           = 12'h344,
    CSR_MCYCLE        = 12'hB00,
    CSR_MINSTRET      = 12'hB02,
    CSR_MCYCLEH       = 12'hB80,
    CSR_MINSTRETH     = 12'hB82,
    CSR_CYCLE         = 12'hC00,
    CSR_TIME          = 12'hC01,
    CSR_INSTRET       = 12'hC02,
    CSR_CYCLEH        = 12'hC80,
    CSR_TIMEH         = 12'hC81,
    CSR_INSTRETH      = 12'hC82,
    CSR_MVENDORID     = 12'hF11,
    CSR_MARCHID       = 12'hF12,
    CSR_MIMPID        = 12'hF13,
    CSR_MHARTID       = 12'hF14,
    CSR_MCONFIGPTR    = 12'hF15
  } csr_addr_e;

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_e;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;  // MPIE, MIE
  localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;  // MPP hardwired M
  localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
  localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;

  state_e      state_q, state_d;
  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] redirect_pc_q;

  logic        idle;
  logic        known;
  logic [31:0] rd_val;
  logic [31:0] wval;
  logic [31:0] mip_vec;
  logic [31:0] irq_pend_vec;
  logic [4:0]  irq_cause;
  logic [31:0] trap_base;
  logic [31:0] target;
  logic        take_exc;
  logic        take_irq;
  logic        take_mret;
  logic        take_any;
  logic        csr_wr_en;

`ifdef TRAP_CSR_COUNTERS_EN
  logic [31:0] mcountinhibit_q;
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;
`else
  logic        unused_inst_retired;
  assign unused_inst_retired = inst_retired;
`endif

  assign idle         = (state_q == IDLE);
  assign mip_vec      = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
  assign irq_pend_vec = mie_q & mip_vec;
  assign irq_pending  = mstatus_q[3] & (|irq_pend_vec);
  assign trap_base    = {mtvec_q[31:2], 2'b00};
  assign take_any     = take_exc | take_irq | take_mret;

  // Address decode and read mux (old value of the addressed CSR)
  always_comb begin
    rd_val = '0;
    known  = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:  rd_val = mstatus_q | MSTATUS_MPP;
      CSR_MISA:     rd_val = MISA_VALUE;
      CSR_MIE:      rd_val = mie_q;
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MTVAL:    rd_val = mtval_q;
      CSR_MIP:      rd_val = mip_vec;
      CSR_MHARTID:  rd_val = HART_ID;
      CSR_MSTATUSH, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR,
      CSR_TIME, CSR_TIMEH:
        rd_val = '0;
`ifdef TRAP_CSR_COUNTERS_EN
      CSR_MCOUNTINHIBIT:         rd_val = mcountinhibit_q;
      CSR_MCYCLE, CSR_CYCLE:     rd_val = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:   rd_val = mcycle_q[63:32];
      CSR_MINSTRET, CSR_INSTRET: rd_val = minstret_q[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret_q[63:32];
`else
      CSR_MCOUNTINHIBIT, CSR_MCYCLE, CSR_CYCLE, CSR_MCYCLEH, CSR_CYCLEH,
      CSR_MINSTRET, CSR_INSTRET, CSR_MINSTRETH, CSR_INSTRETH:
        rd_val = '0;
`endif
      default:      known = 1'b0;
    endcase
  end

  // Read-modify-write operand for the addressed CSR
  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = rd_val | csr_wdata;
      2'b11:   wval = rd_val & ~csr_wdata;
      default: wval = rd_val;
    endcase
  end

  assign csr_illegal = csr_en & idle &
                       (~known | ((&csr_addr[11:10]) & csr_wr) | (csr_op == 2'b00));
  assign csr_wr_en   = csr_en & idle & ~csr_illegal & csr_wr & ~take_any;
  assign csr_rdata   = (csr_en & idle) ? rd_val : '0;
  assign csr_ready   = idle;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_pc_q;

  // Trap arbitration, redirect target and next-state selection
  always_comb begin
    state_d   = state_q;
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    target    = trap_base;
    if (irq_pend_vec[11])     irq_cause = 5'd11;
    else if (irq_pend_vec[3]) irq_cause = 5'd3;
    else                      irq_cause = 5'd7;
    case (state_q)
      IDLE: begin
        if (exc_valid) begin
          take_exc = 1'b1;
          state_d  = REDIRECT;
        end else if (irq_pending) begin
          take_irq = 1'b1;
          state_d  = REDIRECT;
          if (mtvec_q[0]) target = trap_base + {25'b0, irq_cause, 2'b00};
        end else if (mret) begin
          take_mret = 1'b1;
          state_d   = REDIRECT;
          target    = mepc_q;
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Redirect target, captured at request and held through REDIRECT
  always_ff @(posedge clk) begin
    if (rst)           redirect_pc_q <= '0;
    else if (take_any) redirect_pc_q <= target;
  end

  // CSR state: trap/mret updates take precedence over a same-cycle CSR write
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (take_exc) begin
      mcause_q  <= {27'b0, exc_code};
      mepc_q    <= exc_pc & ~32'h3;
      mtval_q   <= exc_tval;
      mstatus_q <= {24'b0, mstatus_q[3], 7'b0};
    end else if (take_irq) begin
      mcause_q  <= {1'b1, 26'b0, irq_cause};
      mepc_q    <= irq_pc & ~32'h3;
      mtval_q   <= '0;
      mstatus_q <= {24'b0, mstatus_q[3], 7'b0};
    end else if (take_mret) begin
      mstatus_q <= {24'b0, 1'b1, 3'b0, mstatus_q[7], 3'b0};
    end else if (csr_wr_en) begin
      case (csr_addr)
        CSR_MSTATUS:  mstatus_q  <= wval & MSTATUS_MASK;
        CSR_MIE:      mie_q      <= wval & MIE_MASK;
        CSR_MTVEC:    mtvec_q    <= wval & ~32'h2;
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval & ~32'h3;
        CSR_MCAUSE:   mcause_q   <= wval;
        CSR_MTVAL:    mtval_q    <= wval;
        default: ;
      endcase
    end
  end

`ifdef TRAP_CSR_COUNTERS_EN
  // Counters: a write to either half replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (rst) begin
      mcountinhibit_q <= '0;
      mcycle_q        <= '0;
      minstret_q      <= '0;
    end else begin
      if (csr_wr_en && csr_addr == CSR_MCOUNTINHIBIT)
        mcountinhibit_q <= wval & 32'h0000_0005;

      if (csr_wr_en && csr_addr == CSR_MCYCLE)
        mcycle_q[31:0] <= wval;
      else if (csr_wr_en && csr_addr == CSR_MCYCLEH)
        mcycle_q[63:32] <= wval;
      else if (!mcountinhibit_q[0])
        mcycle_q <= mcycle_q + 64'd1;

      if (csr_wr_en && csr_addr == CSR_MINSTRET)
        minstret_q[31:0] <= wval;
      else if (csr_wr_en && csr_addr == CSR_MINSTRETH)
        minstret_q[63:32] <= wval;
      else if (inst_retired && !mcountinhibit_q[2])
        minstret_q <= minstret_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_csr.sv
// tb_trap_csr: directed scenarios plus randomized traffic for trap_csr,
// checked every cycle against a behavioural model of the CSR file.
module tb_trap_csr;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0000;
  localparam logic [31:0] HART      = 32'd0;
  localparam logic [11:0] KNOWN [26] = '{
    12'h300, 12'h301, 12'h304, 12'h305, 12'h310, 12'h320, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hF15,
    12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC01, 12'hC02, 12'hC80,
    12'hC81, 12'hC82};

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_wr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_ready;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic [31:0] irq_pc;
  logic        meip, msip, mtip;
  logic        mret;
  logic        inst_retired;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        irq_pending;

  trap_csr #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
    .clk(clk), .rst(rst),
    .csr_en(csr_en), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wr(csr_wr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .csr_ready(csr_ready),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .irq_pc(irq_pc),
    .meip(meip), .msip(msip), .mtip(mtip),
    .mret(mret), .inst_retired(inst_retired),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model state
  bit          m_busy;
  logic [31:0] m_rpc;
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [31:0] m_inh;
  logic [63:0] m_cyc, m_ins;

  // Outputs observed at the last sampling point
  logic [31:0] obs_rdata, obs_rpc;
  logic        obs_illegal, obs_ready, obs_valid, obs_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_known(input logic [11:0] a);
    for (int i = 0; i < 26; i++) if (KNOWN[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mip_now();
    logic [31:0] v;
    v = '0;
    v[11] = meip;
    v[7]  = mtip;
    v[3]  = msip;
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      12'h300: begin v = 32'h0000_1800; v[7] = m_mpie; v[3] = m_mie; end
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie_r;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = mip_now();
      12'hF14: v = HART;
`ifdef TRAP_CSR_COUNTERS_EN
      12'h320:          v = m_inh;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit exp_illegal();
    return csr_en && !m_busy &&
           (!is_known(csr_addr) || (csr_addr[11:10] == 2'b11 && csr_wr) || csr_op == 2'b00);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rpc = '0; m_mie = 0; m_mpie = 0;
    m_mie_r = '0; m_mtvec = MTVEC_RST & ~32'h3; m_mscratch = '0;
    m_mepc = '0; m_mcause = '0; m_mtval = '0;
    m_inh = '0; m_cyc = '0; m_ins = '0;
  endtask

  task automatic enter_trap();
    m_mpie = m_mie;
    m_mie  = 1'b0;
    m_busy = 1'b1;
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic model_step();
    logic [31:0] pend, old, nv, base, inh_old;
    int unsigned cause;
    bit wr_ok;
    wr_ok = 0;
    nv = '0;
    inh_old = m_inh;
    if (rst) begin
      model_reset();
      return;
    end
    base = {m_mtvec[31:2], 2'b00};
    if (m_busy) begin
      if (redirect_ready) m_busy = 0;
    end else begin
      pend = m_mie_r & mip_now();
      if (exc_valid) begin
        m_mcause = 32'(exc_code);
        m_mepc   = exc_pc & ~32'h3;
        m_mtval  = exc_tval;
        m_rpc    = base;
        enter_trap();
      end else if (m_mie && pend != 0) begin
        cause    = pend[11] ? 11 : (pend[3] ? 3 : 7);
        m_mcause = 32'h8000_0000 + cause;
        m_mepc   = irq_pc & ~32'h3;
        m_mtval  = '0;
        m_rpc    = m_mtvec[0] ? base + 4 * cause : base;
        enter_trap();
      end else if (mret) begin
        m_rpc  = m_mepc;
        m_mie  = m_mpie;
        m_mpie = 1'b1;
        m_busy = 1'b1;
      end else if (csr_en && csr_wr && !exp_illegal()) begin
        wr_ok = 1;
        old = model_read(csr_addr);
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = old | csr_wdata;
          default: nv = old & ~csr_wdata;
        endcase
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_r    = nv & 32'h888;
          12'h305: m_mtvec    = nv & ~32'h2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
`ifdef TRAP_CSR_COUNTERS_EN
          12'h320: m_inh      = nv & 32'h5;
`endif
          default: ;
        endcase
      end
    end
`ifdef TRAP_CSR_COUNTERS_EN
    if (wr_ok && csr_addr == 12'hB00)      m_cyc[31:0]  = nv;
    else if (wr_ok && csr_addr == 12'hB80) m_cyc[63:32] = nv;
    else if (!inh_old[0])                  m_cyc = m_cyc + 1;
    if (wr_ok && csr_addr == 12'hB02)      m_ins[31:0]  = nv;
    else if (wr_ok && csr_addr == 12'hB82) m_ins[63:32] = nv;
    else if (inst_retired && !inh_old[2])  m_ins = m_ins + 1;
`else
    if (wr_ok && nv == 32'hx) m_cyc = '0;
`endif
  endtask

  // One clock: sample/compare at the falling edge, then let the edge happen
  task automatic tick();
    @(negedge clk);
    obs_rdata   = csr_rdata;
    obs_rpc     = redirect_pc;
    obs_illegal = csr_illegal;
    obs_ready   = csr_ready;
    obs_valid   = redirect_valid;
    obs_irq     = irq_pending;
    if (!rst) begin
      check("csr_ready", 32'(csr_ready), 32'(!m_busy));
      check("redirect_valid", 32'(redirect_valid), 32'(m_busy));
      if (m_busy) check("redirect_pc", redirect_pc, m_rpc);
      check("irq_pending", 32'(irq_pending), 32'(m_mie && ((m_mie_r & mip_now()) != 0)));
      check("csr_illegal", 32'(csr_illegal), 32'(exp_illegal()));
      check("csr_rdata", csr_rdata,
            (csr_en && !m_busy) ? model_read(csr_addr) : 32'h0);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csr_en = 0; csr_addr = '0; csr_op = '0; csr_wr = 0; csr_wdata = '0;
    exc_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0; irq_pc = '0;
    meip = 0; msip = 0; mtip = 0; mret = 0; inst_retired = 0; redirect_ready = 0;
  endtask

  task automatic csr_access(input logic [11:0] a, input logic [1:0] op,
                            input logic wr, input logic [31:0] d);
    csr_en = 1; csr_addr = a; csr_op = op; csr_wr = wr; csr_wdata = d;
    tick();
    csr_en = 0; csr_wr = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    tick();
    check("rst_ready", 32'(obs_ready), 32'd1);
    check("rst_valid", 32'(obs_valid), 32'd0);
    check("rst_rpc", obs_rpc, 32'h0);
    check("rst_irq", 32'(obs_irq), 32'd0);
    csr_access(12'h301, 2'b10, 0, '0); check("rst_misa", obs_rdata, 32'h4000_0100);
    csr_access(12'h305, 2'b10, 0, '0); check("rst_mtvec", obs_rdata, MTVEC_RST);
    csr_access(12'h300, 2'b10, 0, '0); check("rst_mstatus", obs_rdata, 32'h0000_1800);

    // mie masking and read-only write attempt
    csr_access(12'h304, 2'b10, 1, 32'hFFFF_FFFF);
    csr_access(12'h304, 2'b10, 0, '0); check("mie_mask", obs_rdata, 32'h0000_0888);
    csr_access(12'hF14, 2'b01, 1, 32'h1234);
    check("mhartid_wr_illegal", 32'(obs_illegal), 32'd1);
    csr_access(12'hF14, 2'b10, 0, '0); check("mhartid", obs_rdata, HART);

    // Exception with redirect back-pressure
    csr_access(12'h305, 2'b01, 1, 32'h200);
    exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    tick();
    check("exc_latency", 32'(obs_valid), 32'd0);
    exc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("exc_hold_valid", 32'(obs_valid), 32'd1);
      check("exc_hold_pc", obs_rpc, 32'h200);
    end
    redirect_ready = 1;
    tick();
    check("exc_accept_valid", 32'(obs_valid), 32'd1);
    redirect_ready = 0;
    csr_access(12'h342, 2'b10, 0, '0); check("exc_mcause", obs_rdata, 32'd2);
    csr_access(12'h341, 2'b10, 0, '0); check("exc_mepc", obs_rdata, 32'h100);
    csr_access(12'h343, 2'b10, 0, '0); check("exc_mtval", obs_rdata, 32'hDEAD);

    // Vectored interrupt, MEI beats MTI, then mret
    csr_access(12'h305, 2'b01, 1, 32'h201);
    csr_access(12'h300, 2'b10, 1, 32'h8);
    meip = 1; mtip = 1; irq_pc = 32'h340;
    tick();
    check("irq_pending_set", 32'(obs_irq), 32'd1);
    meip = 0; mtip = 0; redirect_ready = 1;
    tick();
    check("irq_redirect_pc", obs_rpc, 32'h22C);
    redirect_ready = 0;
    csr_access(12'h342, 2'b10, 0, '0); check("irq_mcause", obs_rdata, 32'h8000_000B);
    csr_access(12'h300, 2'b10, 0, '0); check("irq_mstatus", obs_rdata, 32'h0000_1880);
    mret = 1;
    tick();
    mret = 0; redirect_ready = 1;
    tick();
    check("mret_pc", obs_rpc, 32'h340);
    redirect_ready = 0;
    csr_access(12'h300, 2'b10, 0, '0); check("mret_mstatus", obs_rdata, 32'h0000_1888);

    // Exception + mret + interrupt + CSR write together
    csr_access(12'h340, 2'b01, 1, 32'hAAAA);
    exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h480; exc_tval = 32'h7;
    mret = 1; meip = 1;
    csr_en = 1; csr_addr = 12'h340; csr_op = 2'b01; csr_wr = 1; csr_wdata = 32'h5555;
    tick();
    idle_inputs();
    redirect_ready = 1;
    tick();
    check("combo_pc", obs_rpc, 32'h200);
    redirect_ready = 0;
    csr_access(12'h342, 2'b10, 0, '0); check("combo_mcause", obs_rdata, 32'd5);
    csr_access(12'h340, 2'b10, 0, '0); check("combo_mscratch", obs_rdata, 32'hAAAA);
    csr_access(12'h341, 2'b10, 0, '0); check("combo_mepc", obs_rdata, 32'h480);

`ifdef TRAP_CSR_COUNTERS_EN
    csr_access(12'hB80, 2'b01, 1, 32'h0);
    csr_access(12'hB00, 2'b01, 1, 32'hFFFF_FFFF);
    tick();
    csr_access(12'hB80, 2'b10, 0, '0); check("mcycle_carry", obs_rdata, 32'd1);
    csr_access(12'h320, 2'b01, 1, 32'h5);
    inst_retired = 1;
    tick();
    tick();
    csr_access(12'hB00, 2'b10, 0, '0); check("mcycle_frozen", obs_rdata, 32'd2);
    csr_access(12'hB02, 2'b10, 0, '0); check("minstret_frozen", obs_rdata, 32'd0);
    inst_retired = 0;
    csr_access(12'h320, 2'b01, 1, 32'h0);
`else
    csr_access(12'hB00, 2'b01, 1, 32'hFFFF_FFFF);
    check("mcycle_legal", 32'(obs_illegal), 32'd0);
    csr_access(12'hB00, 2'b10, 0, '0); check("mcycle_zero", obs_rdata, 32'd0);
`endif

    // Randomized traffic, including occasional resets mid-redirect
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      csr_en       = $urandom_range(0, 1) == 1;
      csr_addr     = ($urandom_range(0, 9) < 8) ? KNOWN[$urandom_range(0, 25)]
                                                : 12'($urandom);
      csr_op       = 2'($urandom);
      csr_wr       = $urandom_range(0, 1) == 1;
      csr_wdata    = $urandom;
      exc_valid    = ($urandom_range(0, 15) == 0);
      exc_code     = 5'($urandom);
      exc_pc       = $urandom;
      exc_tval     = $urandom;
      irq_pc       = $urandom;
      meip         = ($urandom_range(0, 7) == 0);
      msip         = ($urandom_range(0, 7) == 0);
      mtip         = ($urandom_range(0, 7) == 0);
      mret         = ($urandom_range(0, 15) == 0);
      inst_retired = $urandom_range(0, 1) == 1;
      redirect_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/trap_csr.md
Name: trap_csr

Overview:
- Machine-mode CSR responder and trap sequencer for the rv32 core.
- Decodes the CSR address map and trap cause codes defined in the rv32 package.
- Serves Zicsr read/modify/write requests from the execute stage.
- Arbitrates exceptions and interrupts, and drives trap entry and mret PC redirects back to fetch.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec. BASE is word aligned; MODE field resets to 0.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- csr_en  in  1  CSR access request this cycle
- csr_addr  in  12  CSR address (rv32::csr_addr_t)
- csr_op  in  2  01 RW, 10 RS, 11 RC; 00 is a no-op
- csr_wr  in  1  write intent: 0 for RS/RC with rs1 = x0, or zero immediate
- csr_wdata  in  32  write operand
- csr_rdata  out  32  old CSR value; combinational
- csr_illegal  out  1  combinational; the core raises an illegal-instruction exception (code 2) when it is set
- csr_ready  out  1  high in IDLE only
- exc_valid  in  1  synchronous exception request
- exc_code  in  5  rv32 TRAP_CODE_* exception value
- exc_pc  in  32  PC of the faulting instruction
- exc_tval  in  32  trap value written to mtval
- irq_pc  in  32  PC of the next unretired instruction, saved on interrupt
- meip, msip, mtip  in  1 each  level interrupt lines
- mret  in  1  mret executed
- inst_retired  in  1  one instruction retired this cycle
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect
- irq_pending  out  1  an enabled interrupt would be taken

Behaviour:
- State machine has two states: IDLE and REDIRECT. Reset state is IDLE.
- Reset values:
  - All outputs 0, except csr_ready = 1.
  - mstatus.MIE = 0, mstatus.MPIE = 0; MPP is hardwired 2'b11.
  - mie, mscratch, mepc, mcause, mtval, mcountinhibit = 0.
  - mtvec = MTVEC_RESET.
- Read-only constant CSRs:
  - misa = 32'h4000_0100.
  - mvendorid, marchid, mimpid, mconfigptr, mstatush = 0.
  - mhartid = HART_ID.
- mip is read-only: {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0}.
- Register bit constraints:
  - mepc[1:0] reads 0.
  - mtvec[1] reads 0.
  - mie keeps bits 11, 7 and 3 only.
- csr_illegal is asserted when csr_en is set and any of the following holds:
  - the address is not in the CSR_ADDR enum;
  - csr_addr[11:10] == 2'b11 and csr_wr is set;
  - csr_op == 00.
- When csr_illegal is set, no state changes.
- Legal write, applied at the clock edge in IDLE with csr_wr set:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
- In REDIRECT, csr_en is ignored and csr_rdata = 0.
- Trap arbitration in IDLE, highest priority first:
  1. exc_valid: mcause = {1'b0, 26'b0, exc_code}; mepc = exc_pc; mtval = exc_tval.
  2. Interrupt, taken only when mstatus.MIE = 1 and (mie & mip) is nonzero. Priority MEI(11) > MSI(3) > MTI(7). mcause = {1'b1, cause}; mepc = irq_pc; mtval = 0.
  3. mret: MIE <= MPIE; MPIE <= 1; redirect_pc = mepc.
- Trap entry (exception or interrupt) also updates: MPIE <= MIE; MIE <= 0.
- Trap target:
  - mtvec MODE = 1 and the trap is an interrupt: target = BASE + 4*cause.
  - Otherwise: target = BASE.
- Any trap or mret moves the FSM to REDIRECT on the next cycle. redirect_valid = 1 and redirect_pc is held stable until redirect_ready.
- REDIRECT exits to IDLE on the cycle redirect_valid and redirect_ready are both high. Latency from request to redirect_valid is 1 cycle.
- In REDIRECT, exc_valid, mret and interrupts are ignored. The core holds off.
- A trap or mret in the same cycle as a CSR write: the CSR write is dropped.
- irq_pending = mstatus.MIE & |(mie & mip). It is combinational, evaluated in any state.
- rst mid-REDIRECT returns to IDLE, deasserts redirect_valid, and restores all reset values.

Optional Feature:
- Macro: TRAP_CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle and minstret are implemented. mcycle/mcycleh and minstret/minstreth are read-write; cycle/cycleh/instret/instreth are read-only aliases.
  - mcycle increments every cycle unless mcountinhibit[0] is set.
  - minstret increments on inst_retired unless mcountinhibit[2] is set.
  - A CSR write to either half of a counter overrides that counter's increment for that cycle.
  - The low-to-high carry wraps 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - time/timeh read 0.
- Undefined: all counter addresses and mcountinhibit read 0, writes are ignored, and they are not illegal.

Test Plan:
- After reset, csr_rdata is checked per address: misa → 32'h4000_0100, mtvec → MTVEC_RESET, mstatus → 32'h0000_1800. csr_ready = 1.
- csrrs mie with wdata 32'hFFFF_FFFF → next read of mie = 32'h0000_0888. A write (csr_wr = 1) to mhartid (0xF14) → csr_illegal = 1 and no state change.
- exc_valid, code 2, exc_pc 32'h100, tval 32'hDEAD, mtvec 32'h200 → 1 cycle later redirect_valid = 1, redirect_pc = 32'h200; mcause = 2, mepc = 32'h100, mtval = 32'hDEAD. redirect_valid stays high for 3 cycles until redirect_ready.
- MIE = 1, mie = 32'h888, mtvec = 32'h201, meip and mtip high together → mcause = 32'h8000_000B, redirect_pc = 32'h22C, MIE = 0, MPIE = 1. Then mret → redirect_pc = mepc, MIE = 1.
- exc_valid, mret and an enabled interrupt all in one cycle → exception taken, mret ignored. A CSR write to mscratch in the same cycle is dropped.
- TRAP_CSR_COUNTERS_EN defined: write mcycle = 32'hFFFF_FFFF with mcycleh = 0 → two cycles later mcycleh = 1. Set mcountinhibit = 5 → both counters freeze.
